// File: rtl/gomoku_pkg.sv
`timescale 1ns/1ps
// gomoku_pkg: board constants, cell/direction encodings and win-scan FSM state.
package gomoku_pkg;

    localparam int unsigned GRID_SIZE = 15;
    localparam int unsigned WIN_LEN   = 5;
    localparam int unsigned CW        = 4;

    typedef enum logic [1:0] {EMPTY = 2'd0, P1 = 2'd1, P2 = 2'd2} cell_e;

    typedef enum logic [1:0] {DIR_H = 2'd0, DIR_V = 2'd1, DIR_DR = 2'd2, DIR_UR = 2'd3} dir_e;

    typedef enum logic [2:0] {StIdle, StSetup, StRead, StCmp, StFin} scan_state_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } step_t;

    // y grows downward, so the up-right diagonal steps toward smaller y.
    function automatic step_t dir_step(dir_e dir, logic neg);
        step_t s;
        unique case (dir)
            DIR_H:  begin s.dx = 2'sd1; s.dy = 2'sd0;  end
            DIR_V:  begin s.dx = 2'sd0; s.dy = 2'sd1;  end
            DIR_DR: begin s.dx = 2'sd1; s.dy = 2'sd1;  end
            DIR_UR: begin s.dx = 2'sd1; s.dy = -2'sd1; end
        endcase
        if (neg) begin
            s.dx = -s.dx;
            s.dy = -s.dy;
        end
        return s;
    endfunction

endpackage

// File: rtl/win_scan_ctrl.sv
`timescale 1ns/1ps
// win_scan_ctrl: walks the four lines through a newly placed stone over a shared,
// granted board read port and reports whether it completes a winning run.
module win_scan_ctrl #(
    parameter int unsigned GRID_SIZE = gomoku_pkg::GRID_SIZE,
    parameter int unsigned WIN_LEN   = gomoku_pkg::WIN_LEN,
    parameter int unsigned CW        = gomoku_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [CW-1:0] start_x_i,
    input  logic [CW-1:0] start_y_i,
    input  logic [1:0]    start_color_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          win_o,
    output logic [1:0]    win_color_o,
    output logic [1:0]    win_dir_o,
    output logic          rd_en_o,
    output logic [CW-1:0] rd_x_o,
    output logic [CW-1:0] rd_y_o,
    input  logic          rd_gnt_i,
    input  logic [1:0]    rd_data_i
);
    import gomoku_pkg::*;

    localparam int unsigned CntW = $clog2(WIN_LEN + 1);

    // Probe coordinates carry one extra bit so -1 and GRID_SIZE are both visible.
    function automatic logic [CW:0] sext(logic signed [1:0] d);
        return {{(CW - 1){d[1]}}, d};
    endfunction

    function automatic logic in_grid(logic [CW:0] p);
        return !p[CW] && ({1'b0, p[CW-1:0]} < (CW + 1)'(GRID_SIZE));
    endfunction

    scan_state_e     state_q, state_d;
    logic [CW-1:0]   org_x_q, org_x_d, org_y_q, org_y_d;
    logic [CW-1:0]   probe_x_q, probe_x_d, probe_y_q, probe_y_d;
    logic [1:0]      color_q, color_d;
    dir_e            dir_q, dir_d;
    logic            side_q, side_d;
    logic [CntW-1:0] count_q, count_d, steps_q, steps_d;
    logic            win_q, win_d;
    logic [1:0]      win_color_q, win_color_d, win_dir_q, win_dir_d;

    step_t       step;
    logic [CW:0] setup_x, setup_y, next_x, next_y;
    logic        advance, start_ok;

    always_comb begin
        state_d     = state_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        probe_x_d   = probe_x_q;
        probe_y_d   = probe_y_q;
        color_d     = color_q;
        dir_d       = dir_q;
        side_d      = side_q;
        count_d     = count_q;
        steps_d     = steps_q;
        win_d       = win_q;
        win_color_d = win_color_q;
        win_dir_d   = win_dir_q;
        advance     = 1'b0;

        step     = dir_step(dir_q, side_q);
        setup_x  = {1'b0, org_x_q} + sext(step.dx);
        setup_y  = {1'b0, org_y_q} + sext(step.dy);
        next_x   = {1'b0, probe_x_q} + sext(step.dx);
        next_y   = {1'b0, probe_y_q} + sext(step.dy);
        start_ok = ((start_color_i == P1) || (start_color_i == P2)) &&
                   in_grid({1'b0, start_x_i}) && in_grid({1'b0, start_y_i});

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    org_x_d     = start_x_i;
                    org_y_d     = start_y_i;
                    color_d     = start_color_i;
                    dir_d       = DIR_H;
                    side_d      = 1'b0;
                    count_d     = CntW'(1);
                    steps_d     = '0;
                    win_d       = 1'b0;
                    win_color_d = 2'd0;
                    win_dir_d   = 2'd0;
                    state_d     = start_ok ? StSetup : StFin;
                end
            end
            StSetup: begin
                steps_d = '0;
                if (in_grid(setup_x) && in_grid(setup_y)) begin
                    probe_x_d = setup_x[CW-1:0];
                    probe_y_d = setup_y[CW-1:0];
                    state_d   = StRead;
                end else begin
                    advance = 1'b1;
                end
            end
            StRead: begin
                if (rd_gnt_i) state_d = StCmp;
            end
            StCmp: begin
                if (rd_data_i == color_q) begin
                    count_d = count_q + CntW'(1);
                    steps_d = steps_q + CntW'(1);
                    if (count_d == CntW'(WIN_LEN)) begin
                        win_d       = 1'b1;
                        win_color_d = color_q;
                        win_dir_d   = dir_q;
                        state_d     = StFin;
                    end else if (in_grid(next_x) && in_grid(next_y) &&
                                 (steps_d < CntW'(WIN_LEN - 1))) begin
                        probe_x_d = next_x[CW-1:0];
                        probe_y_d = next_y[CW-1:0];
                        state_d   = StRead;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The minus side keeps the plus side's count; a new direction restarts at 1.
        if (advance) begin
            if (!side_q) begin
                side_d  = 1'b1;
                state_d = StSetup;
            end else if (dir_q == DIR_UR) begin
                state_d = StFin;
            end else begin
                dir_d   = dir_e'(dir_q + 2'd1);
                side_d  = 1'b0;
                count_d = CntW'(1);
                state_d = StSetup;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            org_x_q     <= '0;
            org_y_q     <= '0;
            probe_x_q   <= '0;
            probe_y_q   <= '0;
            color_q     <= 2'd0;
            dir_q       <= DIR_H;
            side_q      <= 1'b0;
            count_q     <= '0;
            steps_q     <= '0;
            win_q       <= 1'b0;
            win_color_q <= 2'd0;
            win_dir_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            probe_x_q   <= probe_x_d;
            probe_y_q   <= probe_y_d;
            color_q     <= color_d;
            dir_q       <= dir_d;
            side_q      <= side_d;
            count_q     <= count_d;
            steps_q     <= steps_d;
            win_q       <= win_d;
            win_color_q <= win_color_d;
            win_dir_q   <= win_dir_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StFin);
    assign rd_en_o     = (state_q == StRead);
    assign rd_x_o      = probe_x_q;
    assign rd_y_o      = probe_y_q;
    assign win_o       = win_q;
    assign win_color_o = win_color_q;
    assign win_dir_o   = win_dir_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
`timescale 1ns/1ps
// tb_win_scan_ctrl: directed scans over a bench-held board; expected results are queued
// at each start and compared when done arrives.
module tb_win_scan_ctrl;
    localparam int G = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] start_x_i, start_y_i;
    logic [1:0] start_color_i;
    logic       busy_o, done_o, win_o;
    logic [1:0] win_color_o, win_dir_o;
    logic       rd_en_o;
    logic [3:0] rd_x_o, rd_y_o;
    logic       rd_gnt;
    logic [1:0] rd_data;

    logic [1:0] board [G][G];  // [y][x]

    typedef struct {
        string      tag;
        int         lat_min;
        int         lat_max;
        logic       win;
        logic [1:0] color;
        logic [1:0] dir;
        int         reads;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rd_log[$];
    int         checks = 0;
    int         errors = 0;

    win_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .start_x_i    (start_x_i),
        .start_y_i    (start_y_i),
        .start_color_i(start_color_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .win_o        (win_o),
        .win_color_o  (win_color_o),
        .win_dir_o    (win_dir_o),
        .rd_en_o      (rd_en_o),
        .rd_x_o       (rd_x_o),
        .rd_y_o       (rd_y_o),
        .rd_gnt_i     (rd_gnt),
        .rd_data_i    (rd_data)
    );

    always #5 clk = ~clk;

    // Board storage: data appears the cycle after a granted request.
    always @(posedge clk) begin
        if (rd_en_o && rd_gnt && int'(rd_x_o) < G && int'(rd_y_o) < G)
            rd_data <= board[int'(rd_y_o)][int'(rd_x_o)];
        else
            rd_data <= 2'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clear_board();
        for (int y = 0; y < G; y++)
            for (int x = 0; x < G; x++)
                board[y][x] = 2'd0;
    endtask

    task automatic push_exp(input string tag, input int lo, input int hi, input logic w,
                            input logic [1:0] c, input logic [1:0] d, input int n);
        exp_t e;
        e.tag = tag; e.lat_min = lo; e.lat_max = hi;
        e.win = w; e.color = c; e.dir = d; e.reads = n;
        sb.push_back(e);
    endtask

    // Runs one start; stall = READ cycles to withhold the grant on the first request,
    // poke = cycle at which a stray start is pulsed while busy (0 = never).
    task automatic scan(input logic [3:0] x, input logic [3:0] y, input logic [1:0] c,
                        input int stall, input int poke);
        exp_t       e;
        int         lat, nreads, bad_rng, stall_bad, stall_left;
        logic       prev_gnt;
        logic [3:0] hx, hy;
        lat = -1; nreads = 0; bad_rng = 0; stall_bad = 0; stall_left = stall;
        hx = '0; hy = '0;
        rd_log.delete();
        start_x_i = x; start_y_i = y; start_color_i = c; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            if (done_o) begin
                lat = k;
            end else begin
                prev_gnt = rd_gnt;
                if (!prev_gnt && (!rd_en_o || rd_x_o !== hx || rd_y_o !== hy)) stall_bad++;
                if (rd_en_o && (int'(rd_x_o) >= G || int'(rd_y_o) >= G)) bad_rng++;
                if (rd_en_o && stall_left > 0) begin
                    rd_gnt = 1'b0; stall_left--; hx = rd_x_o; hy = rd_y_o;
                end else begin
                    rd_gnt = 1'b1;
                end
                if (rd_en_o && rd_gnt) begin
                    nreads++;
                    rd_log.push_back({rd_x_o, rd_y_o});
                end
                if (k == poke) begin
                    start_x_i = 4'd0; start_y_i = 4'd0; start_color_i = 2'd2;
                end
                start_i = (k == poke);
                @(posedge clk); #1;
            end
        end
        start_i = 1'b0;
        rd_gnt  = 1'b1;
        check("scoreboard entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_rng({e.tag, " done latency"}, lat, e.lat_min, e.lat_max);
            check({e.tag, " win"}, win_o, e.win);
            check({e.tag, " win_color"}, win_color_o, e.color);
            check({e.tag, " win_dir"}, win_dir_o, e.dir);
            check({e.tag, " reads"}, nreads, e.reads);
            check({e.tag, " read range"}, bad_rng, 0);
            check({e.tag, " stall hold"}, stall_bad, 0);
            @(posedge clk); #1;
            check({e.tag, " done pulse"}, {busy_o, done_o}, 2'b00);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check({e.tag, " win held"}, {win_o, win_color_o, win_dir_o},
                  {e.win, e.color, e.dir});
        end
    endtask

    logic [7:0] corner_exp [3];
    int         found, done_seen;

    initial begin
        rst = 1'b1; start_i = 1'b0; start_x_i = '0; start_y_i = '0; start_color_i = '0;
        rd_gnt = 1'b1;
        clear_board();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset win", win_o, 0);
        check("reset win_color", win_color_o, 0);
        check("reset win_dir", win_dir_o, 0);
        check("reset rd_en", rd_en_o, 0);
        check("reset rd_x", rd_x_o, 0);
        check("reset rd_y", rd_y_o, 0);

        // Lone stone, with a stray start while busy that must be ignored.
        board[7][7] = 2'd1;
        push_exp("lone", 25, 25, 1'b0, 2'd0, 2'd0, 8);
        scan(4'd7, 4'd7, 2'd1, 0, 5);

        // Row of P1 to the left completes on the minus side of H.
        clear_board();
        for (int x = 3; x <= 7; x++) board[7][x] = 2'd1;
        push_exp("row", 13, 13, 1'b1, 2'd1, 2'd0, 5);
        scan(4'd7, 4'd7, 2'd1, 0, 0);

        // Same row, grant withheld for three cycles on the first read.
        push_exp("row stall", 16, 16, 1'b1, 2'd1, 2'd0, 5);
        scan(4'd7, 4'd7, 2'd1, 3, 0);

        // Corner: only three in-grid probes.
        clear_board();
        board[0][0] = 2'd1;
        push_exp("corner", 15, 15, 1'b0, 2'd0, 2'd0, 3);
        scan(4'd0, 4'd0, 2'd1, 0, 0);
        corner_exp[0] = 8'h10; corner_exp[1] = 8'h01; corner_exp[2] = 8'h11;
        for (int i = 0; i < 3; i++)
            check($sformatf("corner read %0d xy", i),
                  (i < rd_log.size()) ? rd_log[i] : 8'hff, corner_exp[i]);

        // Rejected starts: bad colour, off-grid coordinate.
        push_exp("bad colour", 1, 2, 1'b0, 2'd0, 2'd0, 0);
        scan(4'd7, 4'd7, 2'd0, 0, 0);
        push_exp("bad coord", 1, 2, 1'b0, 2'd0, 2'd0, 0);
        scan(4'd15, 4'd3, 2'd1, 0, 0);

        // P2 up-right diagonal.
        clear_board();
        board[2][10] = 2'd2; board[3][9] = 2'd2; board[4][8] = 2'd2; board[5][7] = 2'd2;
        board[6][6] = 2'd2;
        push_exp("diag", 28, 28, 1'b1, 2'd2, 2'd3, 10);
        scan(4'd6, 4'd6, 2'd2, 0, 0);

        // Repeat with reset asserted while a read is outstanding.
        start_x_i = 4'd6; start_y_i = 4'd6; start_color_i = 2'd2; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (rd_en_o) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("mid-scan read seen", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset rd_en drop", rd_en_o, 0);
        check("reset busy drop", busy_o, 0);
        check("reset clears win", win_o, 0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) done_seen++;
        end
        check("no done after reset", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
